mem_arbiter: RTL and testbench

- Shares the single mem_if Avalon-MM slave between two masters.
- Master 0 is the stimulus reader. Master 1 is the result/log writer, which also does host readback.
- Arbitration is round-robin with a bounded hold.
- Read responses are steered back to the issuing master through an in-order tag FIFO.

---
 rtl/mem_arbiter.sv | 192 +++++++++++++++++++
 tb/tb_mem_arbiter.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-master round-robin arbiter in front of the single mem_if Avalon-MM slave.
// Read responses are steered back to their issuer through an in-order tag FIFO.
module mem_arbiter #(
  parameter int ADDR_WIDTH = 20,
  parameter int DATA_WIDTH = 16,
  parameter int BE_WIDTH   = DATA_WIDTH / 8,
  parameter int MAX_HOLD   = 16,
  parameter int TAG_DEPTH  = 4,
  parameter int TAG_AW     = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] m0_address,
  input  logic [BE_WIDTH-1:0]   m0_byteenable,
  input  logic                  m0_read,
  input  logic                  m0_write,
  input  logic [DATA_WIDTH-1:0] m0_writedata,
  output logic [DATA_WIDTH-1:0] m0_readdata,
  output logic                  m0_readdataready,
  output logic                  m0_waitrequest,
  input  logic [ADDR_WIDTH-1:0] m1_address,
  input  logic [BE_WIDTH-1:0]   m1_byteenable,
  input  logic                  m1_read,
  input  logic                  m1_write,
  input  logic [DATA_WIDTH-1:0] m1_writedata,
  output logic [DATA_WIDTH-1:0] m1_readdata,
  output logic                  m1_readdataready,
  output logic                  m1_waitrequest,
  output logic [ADDR_WIDTH-1:0] s_address,
  output logic [BE_WIDTH-1:0]   s_byteenable,
  output logic                  s_read,
  output logic                  s_write,
  output logic [DATA_WIDTH-1:0] s_writedata,
  input  logic [DATA_WIDTH-1:0] s_readdata,
  input  logic                  s_readdataready,
  input  logic                  s_waitrequest,
  output logic                  err_unexpected
);

  localparam int HOLD_W = $clog2(MAX_HOLD + 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX     = HOLD_W'(MAX_HOLD);
  localparam logic [TAG_AW:0]   TAG_FULL_CNT = (TAG_AW + 1)'(TAG_DEPTH);

  typedef enum logic [1:0] {IDLE = 2'd0, OWN0 = 2'd1, OWN1 = 2'd2} state_t;

  state_t              state_reg, state_next;
  logic                last_owner_reg;
  logic [HOLD_W-1:0]   hold_cnt_reg, hold_cnt_next, hold_cnt_inc;
  logic                hold_limit;
  logic                err_reg;

  logic                tag_mem_reg [TAG_DEPTH];
  logic [TAG_AW-1:0]   wr_ptr_reg, rd_ptr_reg;
  logic [TAG_AW:0]     count_reg;
  logic                fifo_empty, tag_full, push, pop, head_tag;

  logic                req0, req1;
  logic                sel_read, sel_write, sel_rd_only;
  logic                active, stall, accept, owner_id;
  logic [1:0]          own_sel, wait_vec, rdr_vec;

  assign req0 = m0_read | m0_write;
  assign req1 = m1_read | m1_write;

  // State register
  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg      <= IDLE;
      last_owner_reg <= 1'b1;
      hold_cnt_reg   <= '0;
    end else begin
      state_reg    <= state_next;
      hold_cnt_reg <= hold_cnt_next;
      if (state_next != state_reg && state_next != IDLE)
        last_owner_reg <= (state_next == OWN1);
    end
  end

  // Hold limit includes this cycle's accept so the owner gets exactly MAX_HOLD transfers.
  assign hold_cnt_inc = (accept && hold_cnt_reg != HOLD_MAX) ? hold_cnt_reg + 1'b1 : hold_cnt_reg;
  assign hold_limit   = (hold_cnt_inc == HOLD_MAX);

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (req0 && req1)
          state_next = last_owner_reg ? OWN0 : OWN1;
        else if (req0)
          state_next = OWN0;
        else if (req1)
          state_next = OWN1;
      end
      OWN0: begin
        if (!req0)
          state_next = req1 ? OWN1 : IDLE;
        else if (hold_limit && req1)
          state_next = OWN1;
      end
      OWN1: begin
        if (!req1)
          state_next = req0 ? OWN0 : IDLE;
        else if (hold_limit && req0)
          state_next = OWN0;
      end
      default: state_next = IDLE;
    endcase
    hold_cnt_next = (state_next != state_reg && state_next != IDLE) ? '0 : hold_cnt_inc;
  end

  // Output mux from the current owner
  always_comb begin
    sel_read     = 1'b0;
    sel_write    = 1'b0;
    s_address    = '0;
    s_byteenable = '0;
    s_writedata  = '0;
    case (state_reg)
      OWN0: begin
        sel_read     = m0_read;
        sel_write    = m0_write;
        s_address    = m0_address;
        s_byteenable = m0_byteenable;
        s_writedata  = m0_writedata;
      end
      OWN1: begin
        sel_read     = m1_read;
        sel_write    = m1_write;
        s_address    = m1_address;
        s_byteenable = m1_byteenable;
        s_writedata  = m1_writedata;
      end
      default: ;
    endcase
  end

  assign own_sel     = {state_reg == OWN1, state_reg == OWN0};
  assign owner_id    = (state_reg == OWN1);
  assign active      = ~reset & (state_reg != IDLE);
  assign sel_rd_only = sel_read & ~sel_write;
  assign stall       = s_waitrequest | (sel_rd_only & tag_full);
  assign s_read      = active & sel_rd_only & ~tag_full;
  assign s_write     = active & sel_write;
  assign accept      = active & (sel_read | sel_write) & ~stall;
  assign push        = accept & sel_rd_only;

  // A pop in the same cycle frees a slot, so a full FIFO does not stall then.
  assign fifo_empty = (count_reg == '0);
  assign pop        = s_readdataready & ~fifo_empty;
  assign tag_full   = (count_reg == TAG_FULL_CNT) & ~pop;
  assign head_tag   = tag_mem_reg[rd_ptr_reg];

  always_ff @(posedge clock) begin
    if (push)
      tag_mem_reg[wr_ptr_reg] <= owner_id;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      err_reg    <= 1'b0;
    end else begin
      if (push)
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      if (push && !pop)
        count_reg <= count_reg + 1'b1;
      else if (pop && !push)
        count_reg <= count_reg - 1'b1;
      if (s_readdataready && fifo_empty)
        err_reg <= 1'b1;
    end
  end

  for (genvar gi = 0; gi < 2; gi++) begin : g_port
    assign wait_vec[gi] = reset | ~own_sel[gi] | stall;
    assign rdr_vec[gi]  = ~reset & pop & (head_tag == 1'(gi));
  end

  assign m0_waitrequest   = wait_vec[0];
  assign m1_waitrequest   = wait_vec[1];
  assign m0_readdataready = rdr_vec[0];
  assign m1_readdataready = rdr_vec[1];
  assign m0_readdata      = s_readdata;
  assign m1_readdata      = s_readdata;
  assign err_unexpected   = err_reg;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a cycle table for the basic flows plus
// hand-written sequences for contention, tag-full, interleaving and reset.
module tb_mem_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic [19:0] m0_address, m1_address, s_address;
  logic [1:0]  m0_byteenable, m1_byteenable, s_byteenable;
  logic        m0_read, m0_write, m1_read, m1_write;
  logic [15:0] m0_writedata, m1_writedata, s_writedata;
  logic [15:0] m0_readdata, m1_readdata, s_readdata;
  logic        m0_readdataready, m1_readdataready;
  logic        m0_waitrequest, m1_waitrequest;
  logic        s_read, s_write, s_readdataready, s_waitrequest;
  logic        err_unexpected;

  always #5 clock = ~clock;

  mem_arbiter dut (
    .clock(clock), .reset(reset),
    .m0_address(m0_address), .m0_byteenable(m0_byteenable), .m0_read(m0_read),
    .m0_write(m0_write), .m0_writedata(m0_writedata), .m0_readdata(m0_readdata),
    .m0_readdataready(m0_readdataready), .m0_waitrequest(m0_waitrequest),
    .m1_address(m1_address), .m1_byteenable(m1_byteenable), .m1_read(m1_read),
    .m1_write(m1_write), .m1_writedata(m1_writedata), .m1_readdata(m1_readdata),
    .m1_readdataready(m1_readdataready), .m1_waitrequest(m1_waitrequest),
    .s_address(s_address), .s_byteenable(s_byteenable), .s_read(s_read),
    .s_write(s_write), .s_writedata(s_writedata), .s_readdata(s_readdata),
    .s_readdataready(s_readdataready), .s_waitrequest(s_waitrequest),
    .err_unexpected(err_unexpected)
  );

  typedef struct {
    logic rst; logic m0_rd; logic m0_wr; logic [19:0] m0_a;
    logic m1_rd; logic m1_wr; logic [19:0] m1_a; logic [15:0] m1_wd;
    logic sw; logic srdr; logic [15:0] srd;
    logic e_srd; logic e_swr; logic [19:0] e_addr; logic [1:0] e_be; logic [15:0] e_wd;
    logic e_w0; logic e_w1; logic e_r0; logic e_r1; logic e_err;
  } vec_t;

  localparam int NV = 21;
  vec_t vec [NV];

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic drive_idle();
    m0_address = '0; m0_read = 0; m0_write = 0;
    m1_address = '0; m1_read = 0; m1_write = 0; m1_writedata = '0;
    s_waitrequest = 0; s_readdataready = 0; s_readdata = '0;
  endtask

  task automatic do_reset();
    drive_idle();
    reset = 1;
    cyc();
    reset = 0;
  endtask

  task automatic apply(input vec_t v);
    reset = v.rst;
    m0_read = v.m0_rd; m0_write = v.m0_wr; m0_address = v.m0_a;
    m1_read = v.m1_rd; m1_write = v.m1_wr; m1_address = v.m1_a; m1_writedata = v.m1_wd;
    s_waitrequest = v.sw; s_readdataready = v.srdr; s_readdata = v.srd;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc_own[$];
    int both_low, mism, n, n_pop;

    // rst m0rd m0wr m0a | m1rd m1wr m1a m1wd | sw srdr srd | srd swr addr be wd | w0 w1 r0 r1 err
    vec[0]  = '{1,0,0,20'h0,  0,0,20'h0, 16'h0,    0,0,16'h0,    0,0,20'h0, 2'b00,16'h0,    1,1,0,0,0};
    vec[1]  = '{0,1,0,20'h0,  0,0,20'h0, 16'h0,    0,0,16'h0,    0,0,20'h0, 2'b00,16'h0,    1,1,0,0,0};
    vec[2]  = '{0,1,0,20'h0,  0,0,20'h0, 16'h0,    0,0,16'h0,    1,0,20'h0, 2'b01,16'h0,    0,1,0,0,0};
    vec[3]  = '{0,1,0,20'h1,  0,0,20'h0, 16'h0,    0,0,16'h0,    1,0,20'h1, 2'b01,16'h0,    0,1,0,0,0};
    vec[4]  = '{0,1,0,20'h2,  0,0,20'h0, 16'h0,    0,1,16'h1000, 1,0,20'h2, 2'b01,16'h0,    0,1,1,0,0};
    vec[5]  = '{0,1,0,20'h3,  0,0,20'h0, 16'h0,    0,1,16'h1001, 1,0,20'h3, 2'b01,16'h0,    0,1,1,0,0};
    vec[6]  = '{0,0,0,20'h0,  0,0,20'h0, 16'h0,    0,1,16'h1002, 0,0,20'h0, 2'b00,16'h0,    0,1,1,0,0};
    vec[7]  = '{0,0,0,20'h0,  0,0,20'h0, 16'h0,    0,1,16'h1003, 0,0,20'h0, 2'b00,16'h0,    1,1,1,0,0};
    vec[8]  = '{0,0,0,20'h0,  0,0,20'h0, 16'h0,    0,0,16'h0,    0,0,20'h0, 2'b00,16'h0,    1,1,0,0,0};
    vec[9]  = '{0,1,0,20'h20, 1,1,20'h10,16'hBEEF, 0,0,16'h0,    0,0,20'h0, 2'b00,16'h0,    1,1,0,0,0};
    vec[10] = '{0,1,0,20'h20, 1,1,20'h10,16'hBEEF, 1,0,16'h0,    0,1,20'h10,2'b11,16'hBEEF, 1,1,0,0,0};
    vec[11] = '{0,1,0,20'h20, 1,1,20'h10,16'hBEEF, 1,0,16'h0,    0,1,20'h10,2'b11,16'hBEEF, 1,1,0,0,0};
    vec[12] = '{0,1,0,20'h20, 1,1,20'h10,16'hBEEF, 1,0,16'h0,    0,1,20'h10,2'b11,16'hBEEF, 1,1,0,0,0};
    vec[13] = '{0,1,0,20'h20, 1,1,20'h10,16'hBEEF, 0,0,16'h0,    0,1,20'h10,2'b11,16'hBEEF, 1,0,0,0,0};
    vec[14] = '{0,1,0,20'h20, 0,0,20'h0, 16'h0,    0,0,16'h0,    0,0,20'h0, 2'b00,16'h0,    1,0,0,0,0};
    vec[15] = '{0,1,0,20'h20, 0,0,20'h0, 16'h0,    0,0,16'h0,    1,0,20'h20,2'b01,16'h0,    0,1,0,0,0};
    vec[16] = '{0,0,0,20'h0,  0,0,20'h0, 16'h0,    0,1,16'h1234, 0,0,20'h0, 2'b00,16'h0,    0,1,1,0,0};
    vec[17] = '{0,0,0,20'h0,  0,0,20'h0, 16'h0,    0,1,16'h5555, 0,0,20'h0, 2'b00,16'h0,    1,1,0,0,0};
    vec[18] = '{0,0,0,20'h0,  0,0,20'h0, 16'h0,    0,0,16'h0,    0,0,20'h0, 2'b00,16'h0,    1,1,0,0,1};
    vec[19] = '{1,0,0,20'h0,  0,0,20'h0, 16'h0,    0,0,16'h0,    0,0,20'h0, 2'b00,16'h0,    1,1,0,0,1};
    vec[20] = '{0,0,0,20'h0,  0,0,20'h0, 16'h0,    0,0,16'h0,    0,0,20'h0, 2'b00,16'h0,    1,1,0,0,0};

    m0_byteenable = 2'b01; m1_byteenable = 2'b11; m0_writedata = 16'h0A0A;
    drive_idle();
    reset = 1;
    cyc();
    cyc();

    for (int k = 0; k < NV; k++) begin
      apply(vec[k]);
      @(negedge clock);
      chk($sformatf("v%0d_s_read", k), s_read, vec[k].e_srd);
      chk($sformatf("v%0d_s_write", k), s_write, vec[k].e_swr);
      chk($sformatf("v%0d_m0_wait", k), m0_waitrequest, vec[k].e_w0);
      chk($sformatf("v%0d_m1_wait", k), m1_waitrequest, vec[k].e_w1);
      chk($sformatf("v%0d_m0_rdr", k), m0_readdataready, vec[k].e_r0);
      chk($sformatf("v%0d_m1_rdr", k), m1_readdataready, vec[k].e_r1);
      chk($sformatf("v%0d_err", k), err_unexpected, vec[k].e_err);
      if (vec[k].e_srd || vec[k].e_swr) begin
        chk($sformatf("v%0d_s_addr", k), s_address, vec[k].e_addr);
        chk($sformatf("v%0d_s_be", k), s_byteenable, vec[k].e_be);
      end
      if (vec[k].e_swr)
        chk($sformatf("v%0d_s_wdata", k), s_writedata, vec[k].e_wd);
      if (vec[k].e_r0)
        chk($sformatf("v%0d_m0_rdata", k), m0_readdata, vec[k].srd);
      $display("vec %0d: s_read=%0b s_write=%0b m0_rdr=%0b m1_rdr=%0b err=%0b",
               k, s_read, s_write, m0_readdataready, m1_readdataready, err_unexpected);
      cyc();
    end

    // Contention: both masters write continuously from reset.
    do_reset();
    m0_write = 1; m0_address = 20'h100;
    m1_write = 1; m1_address = 20'h200;
    both_low = 0;
    for (int i = 0; i < 41; i++) begin
      @(negedge clock);
      if (!m0_waitrequest && !m1_waitrequest) both_low++;
      if (s_write && !m0_waitrequest) acc_own.push_back(0);
      else if (s_write && !m1_waitrequest) acc_own.push_back(1);
      cyc();
    end
    mism = 0;
    for (int i = 0; i < acc_own.size(); i++)
      if (acc_own[i] != ((i < 16) ? 0 : (i < 32) ? 1 : 0)) mism++;
    chk("contention_accepts", acc_own.size(), 40);
    chk("contention_order_mismatches", mism, 0);
    chk("contention_acc15_owner", acc_own[15], 0);
    chk("contention_acc16_owner", acc_own[16], 1);
    chk("contention_acc32_owner", acc_own[32], 0);
    chk("contention_nonowner_wait", both_low, 0);
    $display("contention: accepts=%0d order_mismatches=%0d", acc_own.size(), mism);

    // Tag full: responses withheld while m0 keeps reading.
    do_reset();
    m0_read = 1; m0_address = 20'h300;
    cyc();
    n = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      if (s_read && !m0_waitrequest) n++;
      cyc();
    end
    chk("tagfull_accepts", n, 4);
    @(negedge clock);
    chk("tagfull_stall_wait", m0_waitrequest, 1);
    chk("tagfull_stall_s_read", s_read, 0);
    cyc();
    s_readdataready = 1; s_readdata = 16'hC0DE;
    @(negedge clock);
    chk("tagfull_pop_s_read", s_read, 1);
    chk("tagfull_pop_wait", m0_waitrequest, 0);
    chk("tagfull_pop_m0_rdr", m0_readdataready, 1);
    cyc();
    s_readdataready = 0;
    @(negedge clock);
    chk("tagfull_still_full", m0_waitrequest, 1);
    cyc();
    m0_read = 0;
    n_pop = 0;
    for (int i = 0; i < 4; i++) begin
      s_readdataready = 1;
      @(negedge clock);
      if (m0_readdataready && !m1_readdataready) n_pop++;
      cyc();
    end
    s_readdataready = 0;
    chk("tagfull_drain", n_pop, 4);
    @(negedge clock);
    chk("tagfull_err", err_unexpected, 0);
    $display("tagfull: accepts=%0d drained=%0d", n, n_pop);
    cyc();

    // Interleaved ownership with reads outstanding from both masters.
    do_reset();
    m0_read = 1; m0_address = 20'h0000A;
    cyc();
    m1_read = 1; m1_address = 20'h0000B;
    @(negedge clock);
    chk("inter_m0_s_read", s_read, 1);
    chk("inter_m0_addr", s_address, 20'h0000A);
    chk("inter_m0_wait", m0_waitrequest, 0);
    chk("inter_m1_wait", m1_waitrequest, 1);
    cyc();
    m0_read = 0;
    @(negedge clock);
    chk("inter_gap_s_read", s_read, 0);
    cyc();
    @(negedge clock);
    chk("inter_m1_s_read", s_read, 1);
    chk("inter_m1_addr", s_address, 20'h0000B);
    chk("inter_m1_wait_low", m1_waitrequest, 0);
    cyc();
    m1_read = 0; s_readdataready = 1; s_readdata = 16'hAAAA;
    @(negedge clock);
    chk("inter_rsp1_m0_rdr", m0_readdataready, 1);
    chk("inter_rsp1_m1_rdr", m1_readdataready, 0);
    chk("inter_rsp1_data", m0_readdata, 16'hAAAA);
    cyc();
    s_readdata = 16'hBBBB;
    @(negedge clock);
    chk("inter_rsp2_m0_rdr", m0_readdataready, 0);
    chk("inter_rsp2_m1_rdr", m1_readdataready, 1);
    chk("inter_rsp2_data", m1_readdata, 16'hBBBB);
    cyc();
    s_readdataready = 0;
    cyc();
    @(negedge clock);
    chk("inter_err", err_unexpected, 0);
    $display("interleave: responses routed m0 then m1");
    cyc();

    // Reset with two reads outstanding, then their late responses.
    do_reset();
    m0_read = 1; m0_address = 20'h00050;
    cyc();
    n = 0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clock);
      if (s_read && !m0_waitrequest) n++;
      cyc();
    end
    chk("rstmid_accepts", n, 2);
    m0_read = 0; reset = 1;
    @(negedge clock);
    chk("rstmid_s_read", s_read, 0);
    chk("rstmid_m0_wait", m0_waitrequest, 1);
    chk("rstmid_m1_wait", m1_waitrequest, 1);
    cyc();
    reset = 0; s_readdataready = 1; s_readdata = 16'h7777;
    @(negedge clock);
    chk("rstmid_rsp1_m0_rdr", m0_readdataready, 0);
    chk("rstmid_rsp1_m1_rdr", m1_readdataready, 0);
    cyc();
    @(negedge clock);
    chk("rstmid_rsp2_m0_rdr", m0_readdataready, 0);
    chk("rstmid_rsp2_m1_rdr", m1_readdataready, 0);
    chk("rstmid_err_set", err_unexpected, 1);
    cyc();
    s_readdataready = 0;
    @(negedge clock);
    chk("rstmid_err_sticky", err_unexpected, 1);
    cyc();
    reset = 1;
    cyc();
    reset = 0;
    @(negedge clock);
    chk("rstmid_err_cleared", err_unexpected, 0);
    $display("reset_midop: err_unexpected cleared by second reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
